// File: rtl/pbus_master.sv
// pbus_master: parallel peripheral-bus master with timed setup/strobe/hold
// phases and a board reset sequence at power-up or soft reset.
module pbus_master #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 3,
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2,
  parameter int RESET_CYCLES  = 100,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  soft_reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic                  cmd_test,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [DATA_WIDTH-1:0] bus_data_out,
  output logic                  bus_data_oe,
  input  logic [DATA_WIDTH-1:0] bus_data_in,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_test_addr,
  output logic                  bus_b0,
  output logic                  bus_rd,
  output logic                  bus_wr,
  output logic                  bus_reset,
  output logic                  busy
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
  } state_t;

  localparam cnt_t RST_LAST = cnt_t'(RESET_CYCLES - 1);
  localparam cnt_t SET_LAST = cnt_t'(SETUP_CYCLES - 1);
  localparam cnt_t STB_LAST = cnt_t'(STROBE_CYCLES - 1);
  localparam cnt_t HLD_LAST = cnt_t'(HOLD_CYCLES - 1);

  state_t state;
  cnt_t   cnt;
  logic   wr_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= INIT;
      cnt           <= '0;
      wr_q          <= 1'b0;
      bus_reset     <= 1'b1;
      bus_b0        <= 1'b0;
      bus_rd        <= 1'b0;
      bus_wr        <= 1'b0;
      bus_data_oe   <= 1'b0;
      bus_data_out  <= '0;
      bus_addr      <= '0;
      bus_test_addr <= 1'b0;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_write     <= 1'b0;
      busy          <= 1'b1;
    end else if (soft_reset) begin
      // Drops any in-flight transaction or pending response
      state       <= INIT;
      cnt         <= '0;
      bus_reset   <= 1'b1;
      bus_b0      <= 1'b0;
      bus_rd      <= 1'b0;
      bus_wr      <= 1'b0;
      bus_data_oe <= 1'b0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      busy        <= 1'b1;
    end else begin
      unique case (state)
        INIT: begin
          if (cnt == RST_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            bus_reset <= 1'b0;
            bus_b0    <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end

        IDLE: begin
          if (cmd_valid) begin
            wr_q          <= cmd_write;
            cmd_ready     <= 1'b0;
            busy          <= 1'b1;
            cnt           <= '0;
            bus_addr      <= cmd_addr;
            bus_test_addr <= cmd_test;
            bus_data_oe   <= cmd_write;
            if (cmd_write) begin
              bus_data_out <= cmd_wdata;
            end
            if (SETUP_CYCLES == 0) begin
              state  <= STROBE;
              bus_wr <= cmd_write;
              bus_rd <= !cmd_write;
            end else begin
              state <= SETUP;
            end
          end
        end

        SETUP: begin
          if (cnt == SET_LAST) begin
            state  <= STROBE;
            cnt    <= '0;
            bus_wr <= wr_q;
            bus_rd <= !wr_q;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end

        STROBE: begin
          if (cnt == STB_LAST) begin
            cnt    <= '0;
            bus_rd <= 1'b0;
            bus_wr <= 1'b0;
            if (!wr_q) begin
              rsp_rdata <= bus_data_in;
            end
            if (HOLD_CYCLES == 0) begin
              state       <= RESP;
              bus_data_oe <= 1'b0;
              rsp_valid   <= 1'b1;
              rsp_write   <= wr_q;
              if (wr_q) begin
                rsp_rdata <= '0;
              end
            end else begin
              state <= HOLD;
            end
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end

        HOLD: begin
          if (cnt == HLD_LAST) begin
            state       <= RESP;
            cnt         <= '0;
            bus_data_oe <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_write   <= wr_q;
            if (wr_q) begin
              rsp_rdata <= '0;
            end
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state <= INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pbus_master.sv
// tb_pbus_master: randomized transactions on two pbus_master instances
// (default timing and zero-length setup/hold) against a timeline model.
module tb_pbus_master;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       soft_reset   [2];
  logic       cmd_valid    [2];
  logic       cmd_ready    [2];
  logic       cmd_write    [2];
  logic       cmd_test     [2];
  logic [2:0] cmd_addr     [2];
  logic [7:0] cmd_wdata    [2];
  logic       rsp_valid    [2];
  logic       rsp_ready    [2];
  logic       rsp_write    [2];
  logic [7:0] rsp_rdata    [2];
  logic [7:0] bus_data_out [2];
  logic       bus_data_oe  [2];
  logic [7:0] bus_data_in  [2];
  logic [2:0] bus_addr     [2];
  logic       bus_test_addr[2];
  logic       bus_b0       [2];
  logic       bus_rd       [2];
  logic       bus_wr       [2];
  logic       bus_reset    [2];
  logic       busy         [2];

  int n_cmp = 0;
  int n_err = 0;
  int cur_u = 0;

  pbus_master #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .SETUP_CYCLES(2),
    .STROBE_CYCLES(4), .HOLD_CYCLES(2), .RESET_CYCLES(100),
    .CNT_WIDTH(8)
  ) u_a (
    .clock(clk), .reset_n(reset_n), .soft_reset(soft_reset[0]),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_write(cmd_write[0]), .cmd_test(cmd_test[0]),
    .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_write(rsp_write[0]), .rsp_rdata(rsp_rdata[0]),
    .bus_data_out(bus_data_out[0]), .bus_data_oe(bus_data_oe[0]),
    .bus_data_in(bus_data_in[0]), .bus_addr(bus_addr[0]),
    .bus_test_addr(bus_test_addr[0]), .bus_b0(bus_b0[0]),
    .bus_rd(bus_rd[0]), .bus_wr(bus_wr[0]),
    .bus_reset(bus_reset[0]), .busy(busy[0])
  );

  pbus_master #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .SETUP_CYCLES(0),
    .STROBE_CYCLES(1), .HOLD_CYCLES(0), .RESET_CYCLES(3),
    .CNT_WIDTH(8)
  ) u_b (
    .clock(clk), .reset_n(reset_n), .soft_reset(soft_reset[1]),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_write(cmd_write[1]), .cmd_test(cmd_test[1]),
    .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_write(rsp_write[1]), .rsp_rdata(rsp_rdata[1]),
    .bus_data_out(bus_data_out[1]), .bus_data_oe(bus_data_oe[1]),
    .bus_data_in(bus_data_in[1]), .bus_addr(bus_addr[1]),
    .bus_test_addr(bus_test_addr[1]), .bus_b0(bus_b0[1]),
    .bus_rd(bus_rd[1]), .bus_wr(bus_wr[1]),
    .bus_reset(bus_reset[1]), .busy(busy[1])
  );

  function automatic int sc(int u);
    return (u == 0) ? 2 : 0;
  endfunction

  function automatic int stb(int u);
    return (u == 0) ? 4 : 1;
  endfunction

  function automatic int hc(int u);
    return (u == 0) ? 2 : 0;
  endfunction

  function automatic int rc(int u);
    return (u == 0) ? 100 : 3;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL u%0d %s: got %0h, expected %0h",
               cur_u, tag, got, exp);
    end
  endtask

  task automatic power_up();
    int fall [2];
    @(negedge clk);
    reset_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      soft_reset[u]  = 1'b0;
      cmd_valid[u]   = 1'b0;
      cmd_write[u]   = 1'b0;
      cmd_test[u]    = 1'b0;
      cmd_addr[u]    = '0;
      cmd_wdata[u]   = '0;
      rsp_ready[u]   = 1'b0;
      bus_data_in[u] = 8'hFF;
    end
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      cur_u = u;
      chk("rst.bus_reset", bus_reset[u], 1);
      chk("rst.b0", bus_b0[u], 0);
      chk("rst.rd", bus_rd[u], 0);
      chk("rst.wr", bus_wr[u], 0);
      chk("rst.oe", bus_data_oe[u], 0);
      chk("rst.dout", bus_data_out[u], 0);
      chk("rst.addr", bus_addr[u], 0);
      chk("rst.test", bus_test_addr[u], 0);
      chk("rst.cmd_ready", cmd_ready[u], 0);
      chk("rst.rsp_valid", rsp_valid[u], 0);
      chk("rst.rdata", rsp_rdata[u], 0);
      chk("rst.rsp_write", rsp_write[u], 0);
      chk("rst.busy", busy[u], 1);
    end
    reset_n = 1'b1;
    fall = '{0, 0};
    for (int c = 1; c <= 110; c++) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (fall[u] == 0 && !bus_reset[u]) fall[u] = c;
      end
    end
    for (int u = 0; u < 2; u++) begin
      cur_u = u;
      chk("init.len", fall[u], rc(u));
      chk("init.b0", bus_b0[u], 1);
      chk("init.cmd_ready", cmd_ready[u], 1);
      chk("init.busy", busy[u], 0);
    end
  endtask

  // abort: 0 none, 1 soft_reset in strobe, 2 async reset in strobe
  task automatic txn(int u, bit w, bit t, logic [2:0] a,
                     logic [7:0] d, logic [7:0] rv, int bp, int abort);
    int s  = sc(u);
    int n  = stb(u);
    int h  = hc(u);
    int kr = 1 + s + n + h;
    int k;
    int cnt;
    bit win;
    bit saw;
    cur_u = u;
    k = 0;
    while (!cmd_ready[u] && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", cmd_ready[u], 1);
    cmd_valid[u]   = 1'b1;
    cmd_write[u]   = w;
    cmd_test[u]    = t;
    cmd_addr[u]    = a;
    cmd_wdata[u]   = d;
    rsp_ready[u]   = 1'b0;
    bus_data_in[u] = 8'hFF;
    @(negedge clk);
    cmd_valid[u] = 1'b0;
    cmd_addr[u]  = 3'($urandom);
    cmd_wdata[u] = 8'($urandom);
    for (k = 1; k <= kr + bp; k++) begin
      win = (k >= 1 + s) && (k < 1 + s + n);
      chk("wr", bus_wr[u], w && win);
      chk("rd", bus_rd[u], !w && win);
      chk("addr", bus_addr[u], a);
      chk("test", bus_test_addr[u], t);
      chk("oe", bus_data_oe[u], w && (k < kr));
      if (w) chk("dout", bus_data_out[u], d);
      chk("rsp_valid", rsp_valid[u], k >= kr);
      chk("cmd_ready", cmd_ready[u], 0);
      chk("busy", busy[u], 1);
      if (k >= kr) begin
        chk("rsp_write", rsp_write[u], w);
        chk("rdata", rsp_rdata[u], w ? 8'h00 : rv);
      end
      if (abort != 0 && k == 1 + s) begin
        if (abort == 1) begin
          soft_reset[u] = 1'b1;
          @(negedge clk);
          soft_reset[u] = 1'b0;
          chk("sr.wr", bus_wr[u], 0);
          chk("sr.rd", bus_rd[u], 0);
          chk("sr.bus_reset", bus_reset[u], 1);
          chk("sr.b0", bus_b0[u], 0);
          chk("sr.oe", bus_data_oe[u], 0);
          chk("sr.cmd_ready", cmd_ready[u], 0);
          chk("sr.rsp_valid", rsp_valid[u], 0);
          cnt = 0;
          saw = 1'b0;
          while (bus_reset[u] && cnt < rc(u) + 10) begin
            @(negedge clk);
            cnt++;
            if (rsp_valid[u]) saw = 1'b1;
          end
          chk("sr.init_len", cnt, rc(u));
          chk("sr.no_rsp", saw, 0);
          chk("sr.b0_up", bus_b0[u], 1);
          chk("sr.cmd_ready", cmd_ready[u], 1);
        end else begin
          #2 reset_n = 1'b0;
          #1;
          chk("ar.wr", bus_wr[u], 0);
          chk("ar.rd", bus_rd[u], 0);
          chk("ar.bus_reset", bus_reset[u], 1);
        end
        return;
      end
      bus_data_in[u] = win ? rv : 8'hFF;
      if (k == kr + bp) begin
        cmd_valid[u] = 1'b0;
        rsp_ready[u] = 1'b1;
      end else if (k >= kr) begin
        cmd_valid[u] = 1'b1;
        cmd_write[u] = 1'($urandom);
      end
      @(negedge clk);
    end
    rsp_ready[u] = 1'b0;
    chk("done.rsp_valid", rsp_valid[u], 0);
    chk("done.cmd_ready", cmd_ready[u], 1);
    chk("done.busy", busy[u], 0);
    chk("done.rd", bus_rd[u], 0);
    chk("done.wr", bus_wr[u], 0);
  endtask

  initial begin
    power_up();

    txn(0, 1'b1, 1'b1, 3'd5, 8'hA7, 8'h00, 0, 0);
    txn(0, 1'b0, 1'b0, 3'd2, 8'h00, 8'h3C, 0, 0);
    txn(0, 1'b0, 1'b1, 3'd7, 8'h00, 8'h5A, 10, 0);
    txn(0, 1'b1, 1'b0, 3'd1, 8'hC4, 8'h00, 10, 0);
    txn(1, 1'b1, 1'b0, 3'd3, 8'h55, 8'h00, 0, 0);
    txn(1, 1'b0, 1'b1, 3'd6, 8'h00, 8'hC3, 2, 0);

    for (int i = 0; i < 20; i++) begin
      int gap;
      gap = $urandom_range(2, 0);
      repeat (gap) @(negedge clk);
      txn($urandom_range(1, 0), 1'($urandom), 1'($urandom),
          3'($urandom), 8'($urandom), 8'($urandom),
          $urandom_range(3, 0), 0);
    end

    txn(0, 1'b1, 1'b1, 3'd4, 8'h99, 8'h00, 0, 1);
    txn(0, 1'b0, 1'b0, 3'd2, 8'h00, 8'h81, 0, 0);
    txn(1, 1'b1, 1'b1, 3'd4, 8'h66, 8'h00, 0, 1);
    txn(1, 1'b0, 1'b0, 3'd5, 8'h00, 8'h18, 0, 0);

    txn(0, 1'b1, 1'b0, 3'd3, 8'h3E, 8'h00, 0, 2);
    power_up();
    txn(0, 1'b0, 1'b1, 3'd0, 8'h00, 8'hE1, 1, 0);
    txn(1, 1'b1, 1'b0, 3'd7, 8'h42, 8'h00, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
